// File: rtl/pe_grant_decoder_if.sv
// pe_grant_decoder_if: lane-set, priority-encoder and grant handshake bundle
// master = decoder side (pe_grant_decoder), slave = lanes/encoder/downstream side
interface pe_grant_decoder_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
);
  logic set_valid;
  logic [WIDTH-1:0] set_mask;
  logic [WIDTH-1:0] pe_in;
  logic pe_request;
  logic pe_work;
  logic [IDX_W-1:0] pe_index;
  logic grant_valid;
  logic grant_ready;
  logic [WIDTH-1:0] grant_onehot;
  logic [IDX_W-1:0] grant_index;
  logic [WIDTH-1:0] pending;
  logic busy;
  logic timeout_err;
  logic check_err;
  modport master (
    input set_valid, set_mask, pe_work, pe_index, grant_ready,
    output pe_in, pe_request, grant_valid, grant_onehot, grant_index,
    output pending, busy, timeout_err, check_err
  );
  modport slave (
    output set_valid, set_mask, pe_work, pe_index, grant_ready,
    input pe_in, pe_request, grant_valid, grant_onehot, grant_index,
    input pending, busy, timeout_err, check_err
  );
endinterface

// File: rtl/pe_grant_decoder.sv
// pe_grant_decoder: BCP pending-flag requester and priority-encoder grant decoder
// Ports: clock (rising edge), reset_n (synchronous, active-low), bus (master modport):
//   set_valid/set_mask in; pe_in/pe_request out; pe_work/pe_index in;
//   grant_valid/grant_onehot/grant_index out, grant_ready in;
//   pending/busy/timeout_err/check_err out. All outputs are registered.
// PE_GRANT_CHECK_EN: when defined, flags encoder results inconsistent with pe_in.
module pe_grant_decoder #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3,
  parameter int WAIT_MAX = 15
) (
  input logic clock,
  input logic reset_n,
  pe_grant_decoder_if.master bus
);
  localparam int CW = $clog2(WAIT_MAX + 1);
  typedef enum logic [1:0] {IDLE, REQ, GRANT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] wait_cnt;
  logic [IDX_W-1:0] idx;
  logic capture, expire;
  logic [WIDTH-1:0] clr, pending_nx;
  always_comb begin
    idx = bus.pe_index;
    capture = state == REQ && !bus.pe_work;
    expire = state == REQ && bus.pe_work && wait_cnt == CW'(WAIT_MAX - 1);
    clr = capture ? WIDTH'(1) << idx : '0;
    // set is ORed after the clear so a re-armed lane stays pending
    pending_nx = (bus.pending & ~clr) | (bus.set_valid ? bus.set_mask : '0);
    state_nx = state == IDLE ? (bus.pending != '0 ? REQ : IDLE) :
               state == REQ ? (capture ? GRANT : expire ? IDLE : REQ) :
               (bus.grant_ready ? IDLE : GRANT);
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      wait_cnt <= '0;
      bus.pending <= '0;
      bus.pe_in <= '0;
      bus.pe_request <= 1'b1;
      bus.grant_valid <= 1'b0;
      bus.grant_onehot <= '0;
      bus.grant_index <= '0;
      bus.timeout_err <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      state <= state_nx;
      bus.pending <= pending_nx;
      bus.busy <= state_nx != IDLE || pending_nx != '0;
      if (state == IDLE && bus.pending != '0) begin
        bus.pe_in <= bus.pending;
        bus.pe_request <= 1'b0;
        wait_cnt <= '0;
      end
      if (state == REQ && bus.pe_work) wait_cnt <= wait_cnt + CW'(1);
      if (capture) begin
        bus.grant_index <= idx;
        bus.grant_onehot <= clr;
        bus.grant_valid <= 1'b1;
        bus.pe_request <= 1'b1;
      end
      if (expire) begin
        bus.pe_request <= 1'b1;
        bus.timeout_err <= 1'b1;
      end
      if (state == GRANT && bus.grant_ready) begin
        bus.grant_valid <= 1'b0;
        bus.grant_onehot <= '0;
      end
    end
  end
`ifdef PE_GRANT_CHECK_EN
  logic [WIDTH-1:0] from_idx;
  // a correct highest-priority result leaves exactly bit 0 after the shift
  always_comb from_idx = bus.pe_in >> idx;
  always_ff @(posedge clock) begin
    if (!reset_n) bus.check_err <= 1'b0;
    else if (capture && from_idx != WIDTH'(1)) bus.check_err <= 1'b1;
  end
`else
  assign bus.check_err = 1'b0;
`endif
endmodule
